cpuc_div: RTL and testbench
===========================

Name: cpuc_div

Overview:
- Sequential unsigned integer divider for the CPUC datapath. It is the inverse arithmetic unit to the combinational multiplier.
- Takes a dividend and a divisor through a valid/ready input handshake and produces quotient and remainder through a valid/ready output handshake.
- Uses a radix-2 restoring algorithm and retires one quotient bit per clock.

Parameters:
- DW, default DATA_WIDTH (cpuc_package), operand and result width in bits.
- CNT_W, default $clog2(DW)+1, iteration counter width; derived, not to be overridden.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept operands.
- dividend  in  DW  unsigned dividend.
- divisor  in  DW  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  DW  unsigned quotient.
- remainder  out  DW  unsigned remainder.
- div_by_zero  out  1  the current result came from a zero divisor; qualified by out_valid.

Behaviour:
- Reset (Rst_n=0 at an edge):
  - state=IDLE; in_ready=1; out_valid=0.
  - quotient, remainder, div_by_zero and all internal registers are 0.
  - Reset dominates every other input at that edge.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE), combinational from state only. It is 0 in BUSY and DONE.
- out_valid = (state==DONE).
- Accept: an edge with state==IDLE and in_valid=1.
  - divisor!=0:
    - Latch dividend into shift register Q.
    - Latch divisor into register D.
    - Clear partial remainder R (DW+1 bits).
    - cnt=0; go to BUSY.
  - divisor==0:
    - quotient={DW{1'b1}}, remainder=dividend, div_by_zero=1.
    - Go directly to DONE; out_valid is high in the next cycle.
- BUSY, each edge performs one iteration:
  - {R,Q} shifts left by 1.
  - Trial value T = R_shifted - {1'b0,D}.
  - If T is non-negative (MSB=0): R=T and Q[0]=1. Otherwise R is kept and Q[0]=0.
  - cnt increments.
  - On the edge where cnt==DW-1 the final iteration completes: state goes to DONE and quotient/remainder are loaded from Q and R[DW-1:0] (the unit may present Q/R directly).
  - div_by_zero=0.
- Latency:
  - Acceptance at edge k → out_valid=1 after edge k+DW. That is DW cycles, independent of operand values; no early termination.
  - Zero divisor: acceptance at edge k → out_valid=1 after edge k.
- DONE:
  - quotient, remainder and div_by_zero stay stable while out_valid=1 and out_ready=0, for an unbounded time.
  - Edge with out_ready=1 → IDLE; out_valid drops in the next cycle.
- Output port values outside DONE:
  - quotient/remainder keep their last values; consumers must qualify them with out_valid.
  - div_by_zero is cleared on accept.
- Throughput: at most one operation every DW+2 cycles (accept, DW iterations, then a DONE/handshake cycle, then IDLE). No overlap between operations.
- in_valid while not IDLE: ignored. Operands are not latched, and the source must hold them until in_ready=1.
- out_ready outside DONE: ignored.
- Reset mid-operation (BUSY or DONE): the operation is discarded and the reset values apply at that edge. No result is emitted after reset.
- Arithmetic invariant for divisor!=0: dividend == quotient*divisor + remainder, with remainder < divisor. All values are unsigned with no sign handling.

Test Plan (DW=32 unless noted):
- Basic: dividend=100, divisor=7 → after exactly 32 cycles out_valid=1, quotient=14, remainder=2, div_by_zero=0; out_ready=1 → IDLE, in_ready=1 one cycle later.
- Boundary: 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0. 5/9 → q=0, r=5. 0/3 → q=0, r=0. 0x80000000/0xFFFFFFFF → q=0, r=0x80000000.
- Divide by zero: dividend=0x1234, divisor=0 → out_valid one cycle after accept, q=0xFFFFFFFF, r=0x1234, div_by_zero=1; the next normal operation reports div_by_zero=0.
- Backpressure and illegal inputs: 1000/10 with out_ready=0 for 20 cycles after out_valid → q=100 and r=0 held stable; in_ready=0 throughout; in_valid pulses with other operands in BUSY/DONE are ignored and do not corrupt the result.
- Reset mid-op: Rst_n=0 for one edge at iteration 10 of 77/3 → at that edge out_valid=0, in_ready=1 and outputs are 0. A following 77/3 yields q=25, r=2 with full 32-cycle latency.
- Random: 10k random pairs (including divisor=0 at 5%), random out_ready → every result satisfies the invariant or the zero-divisor rule; handshake count in equals count out.

Source files
------------

// File: rtl/cpuc_div.sv
// cpuc_div: radix-2 restoring unsigned divider.
// One quotient bit per clock, valid/ready on both sides.
package cpuc_package;
  localparam int DATA_WIDTH = 32;
endpackage

module cpuc_div
  import cpuc_package::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int CNT_W = $clog2(DW) + 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, nxt;

  logic [DW-1:0]  q_r;
  logic [DW-1:0]  d_r;
  logic [DW:0]    r_r;
  logic [CNT_W-1:0] cnt;

  logic [DW+1:0] rs;
  logic [DW+1:0] t;
  logic [DW:0]   r_n;
  logic [DW-1:0] q_n;
  logic          last;
  logic          zdiv;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt == CNT_W'(DW - 1));
  assign zdiv      = (divisor == '0);

  // one restoring step: shift {R,Q}, trial-subtract D, keep or restore
  always_comb begin
    rs  = {r_r, q_r[DW-1]};
    t   = rs - {2'b00, d_r};
    r_n = rs[DW:0];
    q_n = {q_r[DW-2:0], 1'b0};
    if (!t[DW+1]) begin
      r_n = t[DW:0];
      q_n = {q_r[DW-2:0], 1'b1};
    end
  end

  // state register
  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (in_valid) nxt = zdiv ? DONE : BUSY;
      BUSY: if (last)     nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default:            nxt = IDLE;
    endcase
  end

  // datapath: operand capture, iteration and result registers
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      q_r         <= '0;
      d_r         <= '0;
      r_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            div_by_zero <= zdiv;
            if (zdiv) begin
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              q_r <= dividend;
              d_r <= divisor;
              r_r <= '0;
              cnt <= '0;
            end
          end
        end
        BUSY: begin
          q_r         <= q_n;
          r_r         <= r_n;
          cnt         <= cnt + 1'b1;
          div_by_zero <= 1'b0;
          if (last) begin
            quotient  <= q_n;
            remainder <= r_n[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpuc_div.sv
// tb_cpuc_div: directed checks for cpuc_div.
// Hand-computed vectors, latency, backpressure, reset.
module tb_cpuc_div;

  localparam int DW = 32;

  logic          Clk;
  logic          Rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;

  int n_cmp;
  int n_bad;

  cpuc_div dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // accept one op, wait for result, check it, then hand it off
  task automatic do_op(input string tag,
                       input logic [DW-1:0] a,
                       input logic [DW-1:0] b,
                       input logic [DW-1:0] eq,
                       input logic [DW-1:0] er,
                       input logic          ez,
                       input int            lat,
                       input int            hold);
    int n;
    chk({tag, ".rdy"}, 64'(in_ready), 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      // junk operands while busy must be ignored
      dividend = 32'hDEAD_BEEF;
      divisor  = 32'd3;
      in_valid = (n % 3 == 1);
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk({tag, ".lat"}, 64'(n), 64'(lat));
    chk({tag, ".q"}, 64'(quotient), 64'(eq));
    chk({tag, ".r"}, 64'(remainder), 64'(er));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(ez));
    for (int i = 0; i < hold; i++) begin
      dividend = 32'd55;
      divisor  = 32'd5;
      in_valid = i[0];
      tick();
      chk({tag, ".hv"}, 64'(out_valid), 64'd1);
      chk({tag, ".hrdy"}, 64'(in_ready), 64'd0);
      chk({tag, ".hq"}, 64'(quotient), 64'(eq));
      chk({tag, ".hr"}, 64'(remainder), 64'(er));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".ov0"}, 64'(out_valid), 64'd0);
    chk({tag, ".ir1"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    n_cmp     = 0;
    n_bad     = 0;
    Rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    chk("rst.rdy", 64'(in_ready), 64'd1);
    chk("rst.ov", 64'(out_valid), 64'd0);
    chk("rst.q", 64'(quotient), 64'd0);
    chk("rst.r", 64'(remainder), 64'd0);
    chk("rst.dbz", 64'(div_by_zero), 64'd0);
    Rst_n = 1'b1;
    tick();

    do_op("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 0);
    do_op("max1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0,
          1'b0, 32, 0);
    do_op("small", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 32, 0);
    do_op("zero", 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 32, 0);
    do_op("msb", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
          32'h8000_0000, 1'b0, 32, 0);
    do_op("dz", 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234,
          1'b1, 0, 0);
    do_op("afterdz", 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 32, 0);
    do_op("bp", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 32, 20);

    // reset in the middle of an operation
    dividend = 32'd77;
    divisor  = 32'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid.busy", 64'(in_ready), 64'd0);
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    chk("mid.ov", 64'(out_valid), 64'd0);
    chk("mid.rdy", 64'(in_ready), 64'd1);
    chk("mid.q", 64'(quotient), 64'd0);
    chk("mid.r", 64'(remainder), 64'd0);
    chk("mid.dbz", 64'(div_by_zero), 64'd0);
    do_op("post", 32'd77, 32'd3, 32'd25, 32'd2, 1'b0, 32, 0);

    // a handful of random pairs against the native operators
    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 0)
        do_op("rndz", ra, rb, 32'hFFFF_FFFF, ra, 1'b1, 0,
              int'($urandom_range(0, 3)));
      else
        do_op("rnd", ra, rb, ra / rb, ra % rb, 1'b0, 32,
              int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
